// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared master-state and direction encodings for the snake game
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } master_state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    // The encoding pairs each direction with its bitwise inverse as the reverse.
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - free-running period counter with a one-cycle strobe on its last count
module snake_tick_gen #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] PERIOD,
    output logic             TICK
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active_period;

    assign TICK = ENABLE && (count == active_period - ONE);

    // Count while enabled; a new PERIOD is only picked up at a wrap so a running period is never cut short
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count         <= '0;
            active_period <= PERIOD;
        end else if (!ENABLE || TICK) begin
            count         <= '0;
            active_period <= PERIOD;
        end else begin
            count         <= count + ONE;
        end
    end

endmodule

// File: rtl/snake_game_sequencer.sv
// rtl/snake_game_sequencer.sv - snake game master FSM, direction arbiter, scorer and tick pacing (option: SNAKE_SEQ_SPEEDUP_EN)
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_DIV   = 5_000_000,
`ifdef SNAKE_SEQ_SPEEDUP_EN
    parameter int SPEED_STEP = 250_000,
`endif
    parameter int WIN_SCORE  = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_U,
    input  logic       BTN_D,
    input  logic       BTN_L,
    input  logic       BTN_R,
    input  logic       REACHED_TARGET,
    output logic [1:0] MASTER_STATE,
    output logic [1:0] NAVIGATION_STATE,
    output logic       GAME_TICK,
    output logic [3:0] SCORE
);

    localparam int         PW      = $clog2(TICK_DIV) + 4;
    localparam logic [3:0] WIN_VAL = 4'(WIN_SCORE);

    master_state_t state;
    dir_t          nav;
    dir_t          pending;
    logic [3:0]    score;
    logic [3:0]    btn_hist;
    logic          hist_armed;
    logic          target_hist;

    logic [3:0]    btn_now;
    logic [3:0]    press;
    logic          any_press;
    dir_t          press_dir;
    logic          press_valid;
    logic          target_rise;
    logic [3:0]    score_inc;
    logic          tick;
    logic          tick_enable;
    logic [PW-1:0] period;

    assign btn_now     = {BTN_U, BTN_D, BTN_L, BTN_R};
    assign tick_enable = (state == ST_PLAY);

    // Edge detect the buttons and target, and pick the winning direction by U > D > L > R priority
    always_comb begin
        press       = hist_armed ? (btn_now & ~btn_hist) : 4'b0000;
        any_press   = |press;
        press_dir   = DIR_RIGHT;
        if (press[3])      press_dir = DIR_UP;
        else if (press[2]) press_dir = DIR_DOWN;
        else if (press[1]) press_dir = DIR_LEFT;
        press_valid = any_press && (press_dir != opposite_dir(nav));
        target_rise = REACHED_TARGET && !target_hist;
        score_inc   = (score == 4'd15) ? score : score + 4'd1;
    end

`ifdef SNAKE_SEQ_SPEEDUP_EN
    // Product width covers 15 * SPEED_STEP so the subtraction below never wraps
    localparam int            MW      = PW + $clog2(SPEED_STEP + 1) + 4;
    localparam int            FLOOR_P = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
    localparam logic [MW-1:0] SLACK   = MW'(TICK_DIV - FLOOR_P);

    logic [MW-1:0] reduction;

    // Shorten the period by SPEED_STEP per apple, clamped at a quarter of the base period
    always_comb begin
        reduction = MW'(score) * MW'(SPEED_STEP);
        if (reduction >= SLACK) period = PW'(FLOOR_P);
        else                    period = PW'(MW'(TICK_DIV) - reduction);
    end
`else
    assign period = PW'(TICK_DIV);
`endif

    snake_tick_gen #(
        .WIDTH (PW)
    ) u_tick_gen (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (tick_enable),
        .PERIOD (period),
        .TICK   (tick)
    );

    // Master FSM: idle/play/win, pending-to-current direction transfer on ticks, and apple counting
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            nav         <= DIR_RIGHT;
            pending     <= DIR_RIGHT;
            score       <= '0;
            btn_hist    <= '0;
            hist_armed  <= 1'b0;
            target_hist <= 1'b0;
        end else begin
            btn_hist    <= btn_now;
            hist_armed  <= 1'b1;
            target_hist <= REACHED_TARGET;
            case (state)
                ST_IDLE: begin
                    nav     <= DIR_RIGHT;
                    pending <= DIR_RIGHT;
                    score   <= '0;
                    if (any_press) state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (press_valid) pending <= press_dir;
                    if (tick)        nav     <= pending;
                    if (target_rise) begin
                        score <= score_inc;
                        if (score_inc == WIN_VAL) state <= ST_WIN;
                    end
                end
                ST_WIN: begin
                    if (any_press) begin
                        state   <= ST_IDLE;
                        nav     <= DIR_RIGHT;
                        pending <= DIR_RIGHT;
                        score   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign MASTER_STATE     = state;
    assign NAVIGATION_STATE = nav;
    assign GAME_TICK        = tick;
    assign SCORE            = score;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// tb/tb_snake_game_sequencer.sv - directed and random checks of snake_game_sequencer against a behavioural model
module tb_snake_game_sequencer;

`ifdef SNAKE_SEQ_SPEEDUP_EN
    localparam int TD = 16;
    localparam int SS = 4;
    localparam int WS = 5;
`else
    localparam int TD = 4;
    localparam int WS = 3;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BTN_U, BTN_D, BTN_L, BTN_R;
    logic       REACHED_TARGET;
    logic [1:0] MASTER_STATE;
    logic [1:0] NAVIGATION_STATE;
    logic       GAME_TICK;
    logic [3:0] SCORE;

    int n_assert = 0;
    int n_fail   = 0;

    // model state: 0 idle, 1 play, 2 win; directions 0 right, 1 down, 2 up, 3 left
    int       m_state, m_nav, m_pend, m_score, m_cnt, m_period;
    bit [3:0] m_hist;
    bit       m_thist, m_armed;

    always #5 CLK = ~CLK;

    snake_game_sequencer #(
        .TICK_DIV   (TD),
`ifdef SNAKE_SEQ_SPEEDUP_EN
        .SPEED_STEP (SS),
`endif
        .WIN_SCORE  (WS)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .BTN_U            (BTN_U),
        .BTN_D            (BTN_D),
        .BTN_L            (BTN_L),
        .BTN_R            (BTN_R),
        .REACHED_TARGET   (REACHED_TARGET),
        .MASTER_STATE     (MASTER_STATE),
        .NAVIGATION_STATE (NAVIGATION_STATE),
        .GAME_TICK        (GAME_TICK),
        .SCORE            (SCORE)
    );

    function automatic int period_for(input int s);
`ifdef SNAKE_SEQ_SPEEDUP_EN
        int floor_p = (TD / 4 > 0) ? TD / 4 : 1;
        int p       = TD - s * SS;
        return (p > floor_p) ? p : floor_p;
`else
        return TD + 0 * s;
`endif
    endfunction

    function automatic bit exp_tick();
        return (m_state == 1) && (m_cnt == m_period - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // One clock of game rules applied to the inputs seen at the edge
    task automatic model_step(input logic [3:0] b, input logic t, input logic r);
        int       o_state, o_score, o_nav, o_pend, dir;
        bit       tick, any, rise;
        bit [3:0] pr;
        int       pri_dir[4] = '{2, 1, 3, 0};
        if (r) begin
            m_state = 0; m_nav = 0; m_pend = 0; m_score = 0;
            m_cnt = 0; m_period = period_for(0);
            m_hist = '0; m_thist = 0; m_armed = 0;
        end else begin
            o_state = m_state; o_score = m_score; o_nav = m_nav; o_pend = m_pend;
            tick = exp_tick();
            pr   = m_armed ? (b & ~m_hist) : 4'b0000;
            any  = (pr != 4'b0000);
            rise = t && !m_thist;
            dir  = -1;
            for (int k = 0; k < 4; k++)
                if (dir < 0 && pr[3-k]) dir = pri_dir[k];
            case (o_state)
                0: if (any) m_state = 1;
                1: begin
                    if (tick) m_nav = o_pend;
                    if (dir >= 0 && dir != 3 - o_nav) m_pend = dir;
                    if (rise) begin
                        m_score = (o_score < 15) ? o_score + 1 : 15;
                        if (m_score == WS) m_state = 2;
                    end
                end
                default: if (any) begin
                    m_state = 0; m_nav = 0; m_pend = 0; m_score = 0;
                end
            endcase
            if (o_state == 1 && !tick) m_cnt++;
            else begin
                m_cnt    = 0;
                m_period = period_for(o_score);
            end
            m_hist = b; m_thist = t; m_armed = 1;
        end
    endtask

    task automatic step(input logic [3:0] b, input logic t, input logic r);
        {BTN_U, BTN_D, BTN_L, BTN_R} = b;
        REACHED_TARGET = t;
        RESET          = r;
        @(posedge CLK);
        model_step(b, t, r);
        @(negedge CLK);
        check("model_master", MASTER_STATE, m_state);
        check("model_nav", NAVIGATION_STATE, m_nav);
        check("model_tick", GAME_TICK, exp_tick());
        check("model_score", SCORE, m_score);
    endtask

`ifdef SNAKE_SEQ_SPEEDUP_EN
    task automatic measure_gap(output int gap);
        int n = 0;
        gap = -1;
        while (!GAME_TICK && n < 4 * TD) begin step(4'b0, 1'b0, 1'b0); n++; end
        if (GAME_TICK) begin
            step(4'b0, 1'b0, 1'b0);
            n = 1;
            while (!GAME_TICK && n < 4 * TD) begin step(4'b0, 1'b0, 1'b0); n++; end
            if (GAME_TICK) gap = n;
        end
    endtask
`endif

    initial begin
        int       ticks;
        bit       seen;
        logic [3:0] cur_b;
        logic     cur_t, cur_r;
        int       g;

        // reset state
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        check("rst_master", MASTER_STATE, 0);
        check("rst_nav", NAVIGATION_STATE, 0);
        check("rst_tick", GAME_TICK, 0);
        check("rst_score", SCORE, 0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("idle_no_tick", GAME_TICK, 0);

        // a one-cycle press starts the game
        step(4'b0001, 1'b0, 1'b0);
        check("enter_play", MASTER_STATE, 1);
        ticks = 0;
        for (int i = 0; i < TD; i++) begin
            if (GAME_TICK) ticks++;
            check("first_tick_phase", GAME_TICK, (i == TD - 1) ? 1 : 0);
            step(4'b0000, 1'b0, 1'b0);
        end
        check("first_period_ticks", ticks, 1);

        // reverse press while heading right is dropped
        step(4'b0010, 1'b0, 1'b0);
        ticks = 0;
        for (int i = 0; i < 3 * TD; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            if (GAME_TICK) ticks++;
        end
        check("three_ticks", ticks, 3);
        check("reverse_dropped", NAVIGATION_STATE, 0);

        // down press turns only at the next tick
        step(4'b0100, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 2 * TD && !seen; i++) begin
            check("no_early_turn", NAVIGATION_STATE, 0);
            if (GAME_TICK) seen = 1;
            step(4'b0000, 1'b0, 1'b0);
        end
        check("tick_seen", seen, 1);
        check("turn_down", NAVIGATION_STATE, 1);

        // back to right, then simultaneous up+down resolves to up
        step(4'b0001, 1'b0, 1'b0);
        repeat (2 * TD) step(4'b0000, 1'b0, 1'b0);
        check("turn_right", NAVIGATION_STATE, 0);
        step(4'b1100, 1'b0, 1'b0);
        repeat (2 * TD) step(4'b0000, 1'b0, 1'b0);
        check("dual_press_up", NAVIGATION_STATE, 2);

        // apples: each held level counts once, last one wins
        for (int k = 1; k <= WS; k++) begin
            step(4'b0000, 1'b1, 1'b0);
            check("score_edge", SCORE, k);
            check("win_state", MASTER_STATE, (k == WS) ? 2 : 1);
            repeat (4) step(4'b0000, 1'b1, 1'b0);
            check("score_held", SCORE, k);
            repeat (3) step(4'b0000, 1'b0, 1'b0);
        end
        ticks = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            if (GAME_TICK) ticks++;
        end
        check("win_no_tick", ticks, 0);
        check("win_nav_frozen", NAVIGATION_STATE, 2);

        // press in WIN returns to IDLE with score cleared
        step(4'b1000, 1'b0, 1'b0);
        check("win_to_idle", MASTER_STATE, 0);
        check("idle_score_clr", SCORE, 0);
        check("idle_nav_clr", NAVIGATION_STATE, 0);

        // reset mid-game with BTN_R held
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("score_two", SCORE, 2);
        step(4'b0001, 1'b0, 1'b1);
        check("midrst_master", MASTER_STATE, 0);
        check("midrst_score", SCORE, 0);
        check("midrst_nav", NAVIGATION_STATE, 0);
        check("midrst_tick", GAME_TICK, 0);
        repeat (4) step(4'b0001, 1'b0, 1'b0);
        check("held_no_restart", MASTER_STATE, 0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        check("repress_restart", MASTER_STATE, 1);

`ifdef SNAKE_SEQ_SPEEDUP_EN
        // period shrinks with apples and clamps at a quarter
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        measure_gap(g);
        measure_gap(g);
        check("gap_two_apples", g, 8);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        measure_gap(g);
        measure_gap(g);
        check("gap_clamped", g, 4);
`endif

        // random levels against the model
        cur_b = 4'b0000;
        cur_t = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) cur_b = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) cur_t = ~cur_t;
            cur_r = ($urandom_range(0, 299) == 0);
            step(cur_b, cur_t, cur_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
